reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Integer register file for the RV32I pipeline: 32 registers × 32 bits, two asynchronous read ports and one synchronous write port.
- Decode stage drives the read ports (rs1/rs2); writeback stage drives the write port (rd).
- Register x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- we  input  1  write enable for the write port.
- rs1_addr  input  ADDR_W  read port 1 register index.
- rs2_addr  input  ADDR_W  read port 2 register index.
- rd_addr  input  ADDR_W  write port register index.
- rd_data  input  XLEN  write data.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).

Behaviour:
- Reset: one clock, synchronous, active-low. At a rising edge with rst=0, all NUM_REGS registers clear to 0 and any write that cycle is ignored.
- Read outputs have no reset of their own. During and after reset they reflect the cleared array, so they read 0 for any address.
- Write: at a rising edge with rst=1, we=1 and rd_addr≠0, reg[rd_addr] ← rd_data. New value is visible on the array from that edge.
- x0: writes with rd_addr=0 are discarded. Reading address 0 on either port always returns 0, regardless of prior writes.
- Read: rs1_data and rs2_data are purely combinational from their address and the array state. Zero-cycle latency; no clock on the read path.
- Both ports are independent. The same address on both ports returns identical data.
- Read-during-write bypass:
  - Condition: we=1, rst=1, rd_addr≠0, and a read address equals rd_addr in the same cycle.
  - Effect: that read port returns rd_data combinationally (write-first), so a writeback-then-decode in the same cycle needs no external forwarding.
  - Bypass is suppressed when rst=0 (port returns 0) and when rd_addr=0.
- Simultaneous write and read to different addresses: the read returns the old contents of its own register; no interaction.
- we=0: the array holds. rd_addr and rd_data are don't-care.
- X/unknown addresses need no defined behaviour. Out-of-range cannot occur because ADDR_W fully decodes NUM_REGS.
- No other state; no FSM.

Decomposition:
- Shared package (riscv_pkg): XLEN, NUM_REGS, REG_ADDR_W constants; typedefs word_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_ADDR_W-1:0]).
- Single module with no sub-modules. Write logic is one always_ff; read/bypass muxes are combinational.
- Read-port logic is the same for both ports and may be factored as a function inside the module.

Test Plan:
- Reset then read: hold rst=0 for 2 cycles, release; read rs1=5, rs2=6 → both 0. Then write 123 to x5 (we=1, rd_addr=5); next cycle read rs1=5, rs2=6 → 123 and 0.
- Dual read: write 456 to x10; read rs1=5, rs2=10 → 123 and 456 simultaneously. Then rs1=rs2=10 → both 456.
- x0 protection: we=1, rd_addr=0, rd_data=999, one edge; read rs1=0, rs2=5 → 0 and 123.
- Bypass: with x7=0, in one cycle set we=1, rd_addr=7, rd_data=0xDEADBEEF, rs1_addr=7, rs2_addr=7 → both ports 0xDEADBEEF before the edge and after it. Same with rd_addr=0 and rs1_addr=0 → 0.
- Write disabled: we=0, rd_addr=5, rd_data=777, one edge → x5 still reads 123.
- Reset mid-operation: with x5=123 and x10=456, assert rst=0 for one edge while we=1, rd_addr=3, rd_data=55 → x3, x5 and x10 all read 0. Release; write x3=55 → reads 55.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and types used across the pipeline.
//   XLEN       : integer register / data path width
//   NUM_REGS   : number of architectural integer registers
//   REG_ADDR_W : register index width, fully decodes NUM_REGS
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : riscv_pkg

// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, write-first bypass.
// Ports:
//   clk      : rising-edge clock for all state updates
//   rst      : synchronous active-low reset, clears the whole array
//   we       : write enable
//   rs1_addr : read port 1 index (decode stage)
//   rs2_addr : read port 2 index (decode stage)
//   rd_addr  : write index (writeback stage)
//   rd_data  : write data
//   rs1_data : read port 1 data, combinational
//   rs2_data : read port 2 data, combinational
module reg_file
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);

  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  logic  wr_en;

  // A write only lands outside reset and never to x0.
  assign wr_en = rst && we && (rd_addr != '0);

  // Next-state of the array: hold, clear on reset, or single-entry update.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en) begin
      regs_d[rd_addr] = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read mux shared by both ports. Reset forces 0 so reads reflect the
  // cleared array even before the first reset edge; the bypass lets a
  // same-cycle writeback reach decode without external forwarding.
  function automatic word_t read_port(input reg_addr_t addr);
    word_t data;
    data = regs_q[addr];
    if (!rst || (addr == '0)) begin
      data = '0;
    end else if (wr_en && (addr == rd_addr)) begin
      data = rd_data;
    end
    return data;
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
  import riscv_pkg::*;

  logic      clk;
  logic      rst;
  logic      we;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  reg_addr_t rd_addr;
  word_t     rd_data;
  word_t     rs1_data;
  word_t     rs2_data;

  int n_cmp;
  int n_err;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply read addresses and let the combinational path settle.
  task automatic rd2(input reg_addr_t a1, input reg_addr_t a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    we       = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    rd_addr  = '0;
    rd_data  = '0;

    // Reset held two cycles; reads are 0 while asserted.
    tick();
    tick();
    rd2(5'd5, 5'd6);
    check("in_reset_rs1", rs1_data, 32'd0);
    check("in_reset_rs2", rs2_data, 32'd0);
    rst = 1'b1;
    #1;
    check("post_reset_rs1", rs1_data, 32'd0);
    check("post_reset_rs2", rs2_data, 32'd0);

    // Write x5 = 123.
    we = 1'b1; rd_addr = 5'd5; rd_data = 32'd123;
    tick();
    we = 1'b0;
    rd2(5'd5, 5'd6);
    check("x5_written", rs1_data, 32'd123);
    check("x6_untouched", rs2_data, 32'd0);

    // Write x10 = 456 while reading x5 (other address unaffected) and x10 (bypass).
    we = 1'b1; rd_addr = 5'd10; rd_data = 32'd456;
    rd2(5'd5, 5'd10);
    check("wr_other_addr_rs1", rs1_data, 32'd123);
    check("wr_bypass_rs2", rs2_data, 32'd456);
    tick();
    we = 1'b0;
    rd2(5'd5, 5'd10);
    check("dual_rs1_x5", rs1_data, 32'd123);
    check("dual_rs2_x10", rs2_data, 32'd456);
    rd2(5'd10, 5'd10);
    check("same_addr_rs1", rs1_data, 32'd456);
    check("same_addr_rs2", rs2_data, 32'd456);

    // x0 write discarded.
    we = 1'b1; rd_addr = 5'd0; rd_data = 32'd999;
    rd2(5'd0, 5'd0);
    check("x0_no_bypass_rs1", rs1_data, 32'd0);
    check("x0_no_bypass_rs2", rs2_data, 32'd0);
    tick();
    we = 1'b0;
    rd2(5'd0, 5'd5);
    check("x0_reads_zero", rs1_data, 32'd0);
    check("x0_keeps_x5", rs2_data, 32'd123);

    // Bypass on x7 (previously 0).
    rd2(5'd7, 5'd7);
    check("x7_initial", rs1_data, 32'd0);
    we = 1'b1; rd_addr = 5'd7; rd_data = 32'hDEADBEEF;
    #1;
    check("bypass_rs1", rs1_data, 32'hDEADBEEF);
    check("bypass_rs2", rs2_data, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    rd_data = 32'h0;
    #1;
    check("after_edge_rs1_x7", rs1_data, 32'hDEADBEEF);
    check("after_edge_rs2_x7", rs2_data, 32'hDEADBEEF);

    // Write disabled: x5 holds.
    we = 1'b0; rd_addr = 5'd5; rd_data = 32'd777;
    rd2(5'd5, 5'd5);
    check("we0_no_bypass", rs1_data, 32'd123);
    tick();
    rd2(5'd5, 5'd7);
    check("we0_x5_holds", rs1_data, 32'd123);
    check("we0_x7_holds", rs2_data, 32'hDEADBEEF);

    // Reset mid-operation with a concurrent write to x3.
    rst = 1'b0; we = 1'b1; rd_addr = 5'd3; rd_data = 32'd55;
    rd2(5'd3, 5'd10);
    check("rst_suppress_bypass", rs1_data, 32'd0);
    check("rst_reads_zero_x10", rs2_data, 32'd0);
    tick();
    rst = 1'b1; we = 1'b0;
    rd2(5'd3, 5'd5);
    check("rst_x3_cleared", rs1_data, 32'd0);
    check("rst_x5_cleared", rs2_data, 32'd0);
    rd2(5'd10, 5'd7);
    check("rst_x10_cleared", rs1_data, 32'd0);
    check("rst_x7_cleared", rs2_data, 32'd0);

    // Write x3 = 55 after reset release.
    we = 1'b1; rd_addr = 5'd3; rd_data = 32'd55;
    tick();
    we = 1'b0;
    rd2(5'd3, 5'd31);
    check("x3_written", rs1_data, 32'd55);
    check("x31_zero", rs2_data, 32'd0);

    // Top address boundary.
    we = 1'b1; rd_addr = 5'd31; rd_data = 32'hA5A5_0F0F;
    tick();
    we = 1'b0;
    rd2(5'd31, 5'd3);
    check("x31_written", rs1_data, 32'hA5A5_0F0F);
    check("x3_still", rs2_data, 32'd55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_reg_file
